serial_pe: RTL and testbench
============================

Name: serial_pe

Overview:
Serial multiply-accumulate processing element: each valid cycle it takes one 16-bit neuron and one 16-bit weight, multiplies them signed and accumulates into a 32-bit sum. ctl marks the first and last beat of a dot-product sequence; at the end of a sequence it presents the 32-bit result with a one-cycle valid pulse. It sits behind a streaming front end that feeds one neuron/weight pair per clock, e.g. an instruction of N×32 beats.

Parameters:
none; all widths fixed: 16-bit operands, 32-bit accumulator and result.

Ports:
clk     input   1   rising-edge clock
rst_n   input   1   asynchronous reset, active-high (asserted = 1) despite the name
neuron  input   16  signed two's-complement neuron operand
weight  input   16  signed two's-complement weight operand
ctl     input   2   ctl[0] = first beat of sequence (restart accumulation); ctl[1] = last beat (emit result)
vld_i   input   1   beat valid; neuron, weight and ctl are sampled only when 1
result  output  32  signed dot-product result, held until the next result
vld_o   output  1   one-cycle pulse: result is new and valid

Behaviour:
- Reset (rst_n=1, asynchronous): all pipeline registers, accumulator, result and vld_o cleared to 0; the in-flight sequence is discarded.
- Two-stage pipeline.
  - Stage 1, edge N with vld_i=1: register the signed 16×16 product (32-bit, exact) and delayed copies of vld_i, ctl[0] and ctl[1].
  - Stage 2, edge N+1 when the delayed valid is 1:
    - delayed ctl[0]=1: acc <= product (restart, no add of the old sum);
    - otherwise: acc <= acc + product, modulo 2^32 (wrap, no saturation, no overflow flag).
  - Stage 2, also at edge N+1, if the delayed ctl[1]=1: result <= new acc value (same value written to acc) and vld_o <= 1; otherwise vld_o <= 0.
- Latency: last beat sampled at edge N gives vld_o=1 and a valid result after edge N+1 (visible in cycle N+1 to N+2); vld_o is high for exactly one cycle per sequence.
- ctl[0] and ctl[1] in the same beat: single-beat sequence; result = that product.
- vld_i=0: a bubble. No state change in acc; ctl and operands are ignored. Bubbles may occur anywhere inside a sequence without changing the result.
- Back-to-back sequences: a new ctl[0] beat may follow the last beat on the very next cycle, at full throughput (1 beat/cycle, no stalls, no backpressure).
- Beats accepted after reset before any ctl[0]: accumulate onto 0.
- ctl[1] with no prior ctl[0]: emits the accumulated sum so far.
- result holds its value between vld_o pulses.
- Multiplier: any bit-exact signed implementation, e.g. a radix-4 Booth partial-product array plus adder tree. Product of 0x8000×0x8000 = 0x40000000.

Test Plan:
- Reset: rst_n=1 mid-run -> result=0x00000000, vld_o=0 immediately; after release, the next ctl[0]..ctl[1] sequence gives a correct fresh sum.
- Single beat: ctl=2'b11, neuron=0x0003, weight=0xFFFE -> vld_o pulses one cycle, two edges after sampling; result=0xFFFFFFFA (-6).
- 32-beat sequence: neuron=0x0002, weight=0x0003 each beat, ctl[0] on beat 0, ctl[1] on beat 31 -> single vld_o pulse; result=0x000000C0.
- Back-to-back plus wrap: a 4-beat sequence of 0x7FFF×0x7FFF immediately followed by a 2-beat sequence of 0xFFFF×0x0005.
  - first: result=0xFFFC0004;
  - second, vld_o exactly 2 cycles later: result=0xFFFFFFF6, with no carry-over from the first.
- Bubbles: the 32-beat case with vld_i low for 5 cycles mid-sequence, ctl toggled arbitrarily while vld_i=0 -> result still 0x000000C0; vld_o delayed by 5 cycles.
- Extremes: ctl=2'b11, neuron=0x8000, weight=0x8000 -> result=0x40000000; neuron=0x8000, weight=0x7FFF -> result=0xC0008000.

Source files
------------

// File: rtl/serial_pe.sv
// serial_pe: two-stage serial multiply-accumulate element.
// Each valid beat multiplies a signed 16-bit neuron by a signed 16-bit weight.
// The 32-bit products are summed into a wrapping accumulator.
// ctl[0] on a beat restarts the sum and ctl[1] on a beat emits it, with a
// one-cycle vld_o pulse.
module serial_pe (
    input  logic        clk,
    input  logic        rst_n,   // active-high despite the name
    input  logic [15:0] neuron,
    input  logic [15:0] weight,
    input  logic [1:0]  ctl,
    input  logic        vld_i,
    output logic [31:0] result,
    output logic        vld_o
);

    // ------------------------------------------------------------------
    // Radix-4 Booth multiplier: 8 signed digits of the weight select
    // 0, +-1 or +-2 times the sign-extended neuron; partial products are
    // summed modulo 2^32, which is exact for a 16x16 signed product.
    // ------------------------------------------------------------------
    logic [31:0]       md_ext;
    logic [31:0]       md_x2;
    logic [16:0]       mr_ext;
    logic [7:0][31:0]  pp;
    logic [3:0][31:0]  sum_l1;
    logic [1:0][31:0]  sum_l2;
    logic [31:0]       prod_d;

    assign md_ext = {{16{neuron[15]}}, neuron};
    assign md_x2  = {md_ext[30:0], 1'b0};
    assign mr_ext = {weight, 1'b0};

    for (genvar g = 0; g < 8; g++) begin : g_booth
        logic [2:0]  sel;
        logic [31:0] mult;

        assign sel = mr_ext[2*g +: 3];

        // Map the Booth digit to its multiple of the neuron
        always_comb begin
            mult = '0;
            case (sel)
                3'b001, 3'b010: mult = md_ext;
                3'b011:         mult = md_x2;
                3'b100:         mult = -md_x2;
                3'b101, 3'b110: mult = -md_ext;
                default:        mult = '0;
            endcase
        end

        assign pp[g] = mult << (2 * g);
    end

    // Balanced adder tree over the eight partial products
    assign sum_l1[0] = pp[0] + pp[1];
    assign sum_l1[1] = pp[2] + pp[3];
    assign sum_l1[2] = pp[4] + pp[5];
    assign sum_l1[3] = pp[6] + pp[7];
    assign sum_l2[0] = sum_l1[0] + sum_l1[1];
    assign sum_l2[1] = sum_l1[2] + sum_l1[3];
    assign prod_d    = sum_l2[0] + sum_l2[1];

    // ------------------------------------------------------------------
    // Pipeline state
    // ------------------------------------------------------------------
    logic [31:0] prod_q;
    logic        vld1_q;
    logic        first_q;
    logic        last_q;
    logic [31:0] acc_q;
    logic [31:0] acc_d;
    logic [31:0] result_q;
    logic        vld_o_q;

    // Stage 1: capture product and beat qualifiers; bubbles leave them untouched
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            prod_q  <= '0;
            vld1_q  <= 1'b0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            vld1_q <= vld_i;
            if (vld_i) begin
                prod_q  <= prod_d;
                first_q <= ctl[0];
                last_q  <= ctl[1];
            end
        end
    end

    // Next accumulator value: restart on a first beat, otherwise wrap-add
    always_comb begin
        acc_d = acc_q + prod_q;
        if (first_q) begin
            acc_d = prod_q;
        end
    end

    // Stage 2: update the accumulator and publish the sum on a last beat
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            acc_q    <= '0;
            result_q <= '0;
            vld_o_q  <= 1'b0;
        end else begin
            vld_o_q <= vld1_q & last_q;
            if (vld1_q) begin
                acc_q <= acc_d;
                if (last_q) begin
                    result_q <= acc_d;
                end
            end
        end
    end

    assign result = result_q;
    assign vld_o  = vld_o_q;

endmodule

// File: tb/tb_serial_pe.sv
// tb_serial_pe: directed self-checking bench for serial_pe.
module tb_serial_pe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] neuron;
    logic [15:0] weight;
    logic [1:0]  ctl;
    logic        vld_i;
    logic [31:0] result;
    logic        vld_o;

    serial_pe dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .neuron (neuron),
        .weight (weight),
        .ctl    (ctl),
        .vld_i  (vld_i),
        .result (result),
        .vld_o  (vld_o)
    );

    always #5 clk = ~clk;

    int n_asserts = 0;
    int n_fails   = 0;
    int cyc       = 0;
    int last_edge = 0;

    logic [31:0] exp_val[$];
    int          exp_cyc[$];
    logic [31:0] got_val[$];
    int          got_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Record every result pulse with the cycle it was seen in
    always @(negedge clk) begin
        if (vld_o === 1'b1) begin
            got_val.push_back(result);
            got_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_asserts++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Present one beat for the next rising edge
    task automatic beat(input logic [15:0] n, input logic [15:0] w,
                        input logic [1:0] c, input logic v);
        @(posedge clk);
        #1;
        neuron = n;
        weight = w;
        ctl    = c;
        vld_i  = v;
        if (v && c[1]) last_edge = cyc;
    endtask

    // Bubbles with junk operands and ctl
    task automatic idle(input int k);
        for (int i = 0; i < k; i++)
            beat(16'($urandom), 16'($urandom), 2'($urandom), 1'b0);
    endtask

    // Last beat sampled at edge E+1 -> pulse seen after edge E+2
    task automatic expect_pulse(input logic [31:0] v);
        exp_val.push_back(v);
        exp_cyc.push_back(last_edge + 2);
    endtask

    task automatic settle(input string tag);
        int n;
        idle(4);
        check($sformatf("%s_npulse", tag), 32'(got_val.size()), 32'(exp_val.size()));
        n = (got_val.size() < exp_val.size()) ? got_val.size() : exp_val.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_val%0d", tag, i), got_val[i], exp_val[i]);
            check($sformatf("%s_cyc%0d", tag, i), 32'(got_cyc[i]), 32'(exp_cyc[i]));
        end
        got_val.delete();
        got_cyc.delete();
        exp_val.delete();
        exp_cyc.delete();
    endtask

    initial begin
        rst_n  = 1'b1;
        neuron = '0;
        weight = '0;
        ctl    = '0;
        vld_i  = 1'b0;
        #1;
        check("init_result", result, 32'h0);
        check("init_vld", {31'b0, vld_o}, 32'h0);
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;

        // Single-beat sequence
        beat(16'h0003, 16'hFFFE, 2'b11, 1'b1);
        expect_pulse(32'hFFFF_FFFA);
        settle("single");

        // 32-beat sequence
        for (int i = 0; i < 32; i++)
            beat(16'h0002, 16'h0003, {i == 31, i == 0}, 1'b1);
        expect_pulse(32'h0000_00C0);
        settle("seq32");

        // Back-to-back with wrap
        for (int i = 0; i < 4; i++)
            beat(16'h7FFF, 16'h7FFF, {i == 3, i == 0}, 1'b1);
        expect_pulse(32'hFFFC_0004);
        for (int i = 0; i < 2; i++)
            beat(16'hFFFF, 16'h0005, {i == 1, i == 0}, 1'b1);
        expect_pulse(32'hFFFF_FFF6);
        settle("b2b");

        // 32-beat sequence with 5 bubbles mid-way
        for (int i = 0; i < 32; i++) begin
            if (i == 16) idle(5);
            beat(16'h0002, 16'h0003, {i == 31, i == 0}, 1'b1);
        end
        expect_pulse(32'h0000_00C0);
        settle("bubble");

        // Extreme and mixed-sign single-beat products, back-to-back
        beat(16'h8000, 16'h8000, 2'b11, 1'b1);
        expect_pulse(32'h4000_0000);
        beat(16'h8000, 16'h7FFF, 2'b11, 1'b1);
        expect_pulse(32'hC000_8000);
        beat(16'hFFFF, 16'hFFFF, 2'b11, 1'b1);
        expect_pulse(32'h0000_0001);
        beat(16'h1234, 16'h5678, 2'b11, 1'b1);
        expect_pulse(32'h0626_0060);
        settle("extreme");

        // Reset asserted while a pulse is visible and a beat is in flight
        beat(16'h0005, 16'h0007, 2'b11, 1'b1);
        beat(16'h0009, 16'h0009, 2'b01, 1'b1);
        @(posedge clk);
        #1;
        vld_i = 1'b0;
        check("pre_rst_vld", {31'b0, vld_o}, 32'h1);
        check("pre_rst_result", result, 32'h0000_0023);
        #1 rst_n = 1'b1;
        #1;
        check("rst_result", result, 32'h0);
        check("rst_vld", {31'b0, vld_o}, 32'h0);
        @(posedge clk);
        #1;
        check("rst_hold_result", result, 32'h0);
        #2 rst_n = 1'b0;

        // After reset: no ctl[0] yet, accumulate onto 0
        beat(16'h0002, 16'h0003, 2'b00, 1'b1);
        beat(16'h0002, 16'h0003, 2'b10, 1'b1);
        expect_pulse(32'h0000_000C);
        // Fresh sequence
        beat(16'h0004, 16'h0005, 2'b01, 1'b1);
        beat(16'hFFFF, 16'h0003, 2'b10, 1'b1);
        expect_pulse(32'h0000_0011);
        // ctl[1] without a new ctl[0] continues the running sum
        beat(16'h0001, 16'h0001, 2'b10, 1'b1);
        expect_pulse(32'h0000_0012);
        settle("post_rst");

        // Result holds between pulses
        idle(3);
        check("hold_result", result, 32'h0000_0012);
        check("hold_vld", {31'b0, vld_o}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
